battleship: RTL and testbench

//  Two-player 4x4 Battleship game controller for an FPGA board. Each player hides 4 ships
//  on a private 4x4 map, then the players alternate single shots at each other's map.

---
 rtl/battleship.sv | 217 +++++++++++++++++++++
 tb/tb_battleship.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/battleship.sv
`default_nettype none
// ============================================================================
// battleship : two-player 4x4 Battleship controller driving 4x7-seg + 8 LEDs
// Rev 1.0
// ============================================================================
module battleship #(
   parameter int TIMER_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] X,
   input  logic [1:0] Y,
   input  logic       pAb,
   input  logic       pBb,
   output logic [7:0] disp3,
   output logic [7:0] disp2,
   output logic [7:0] disp1,
   output logic [7:0] disp0,
   output logic [7:0] led
);

   localparam int            TW      = (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;
   localparam logic [TW-1:0] C_TLAST = TW'(TIMER_CYCLES - 1);

   localparam logic [7:0] C_G_I    = 8'h06;
   localparam logic [7:0] C_G_D    = 8'h5E;
   localparam logic [7:0] C_G_L    = 8'h38;
   localparam logic [7:0] C_G_E    = 8'h79;
   localparam logic [7:0] C_G_A    = 8'h77;
   localparam logic [7:0] C_G_B    = 8'h7C;
   localparam logic [7:0] C_G_R    = 8'h50;
   localparam logic [7:0] C_G_DASH = 8'h40;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,  SHOW    = 4'd1,  A_IN    = 4'd2,  ERR_A   = 4'd3,
      SHOW_A  = 4'd4,  B_IN    = 4'd5,  ERR_B   = 4'd6,  SHOW_B  = 4'd7,
      A_SHOOT = 4'd8,  A_SINK  = 4'd9,  A_WIN   = 4'd10, B_SHOOT = 4'd11,
      B_SINK  = 4'd12, B_WIN   = 4'd13
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [15:0]     mapA;
   logic [15:0]     mapB;
   logic [2:0]      score_A;
   logic [2:0]      score_B;
   logic [2:0]      input_count;
   logic [TW-1:0]   timer;
   logic            pAb_q;
   logic            pBb_q;
   logic            r_hit;
   logic            r_blink;

   logic            w_pA_press;
   logic            w_pB_press;
   logic            w_tdone;
   logic [3:0]      w_idx;

   assign w_pA_press = pAb & ~pAb_q;
   assign w_pB_press = pBb & ~pBb_q;
   assign w_tdone    = (timer == C_TLAST);
   assign w_idx      = {Y, X};

   function automatic logic [7:0] f_digit(input logic [2:0] n);
      case (n)
         3'd0:    f_digit = 8'h3F;
         3'd1:    f_digit = 8'h06;
         3'd2:    f_digit = 8'h5B;
         3'd3:    f_digit = 8'h4F;
         3'd4:    f_digit = 8'h66;
         default: f_digit = 8'h00;
      endcase
   endfunction

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start)      next_state = SHOW;
         SHOW:    if (w_tdone)    next_state = A_IN;
         A_IN:    if (w_pA_press) next_state = mapA[w_idx] ? ERR_A : SHOW_A;
         ERR_A:   if (w_tdone)    next_state = A_IN;
         SHOW_A:  if (w_tdone)    next_state = (input_count < 3'd4) ? A_IN : B_IN;
         B_IN:    if (w_pB_press) next_state = mapB[w_idx] ? ERR_B : SHOW_B;
         ERR_B:   if (w_tdone)    next_state = B_IN;
         SHOW_B:  if (w_tdone)    next_state = (input_count < 3'd4) ? B_IN : A_SHOOT;
         A_SHOOT: if (w_pA_press) next_state = A_SINK;
         A_SINK:  if (w_tdone)    next_state = (score_A == 3'd4) ? A_WIN : B_SHOOT;
         B_SHOOT: if (w_pB_press) next_state = B_SINK;
         B_SINK:  if (w_tdone)    next_state = (score_B == 3'd4) ? B_WIN : A_SHOOT;
         A_WIN:   next_state = A_WIN;
         B_WIN:   next_state = B_WIN;
         default: next_state = IDLE;
      endcase
   end

   // Edge registers update every cycle so presses outside a player's turn are consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mapA        <= '0;
         mapB        <= '0;
         score_A     <= '0;
         score_B     <= '0;
         input_count <= '0;
         timer       <= '0;
         pAb_q       <= 1'b0;
         pBb_q       <= 1'b0;
         r_hit       <= 1'b0;
         r_blink     <= 1'b0;
      end else begin
         pAb_q <= pAb;
         pBb_q <= pBb;
         state <= next_state;
         if (next_state != state || w_tdone)
            timer <= '0;
         else
            timer <= timer + 1'b1;
         if ((state == A_WIN || state == B_WIN) && w_tdone)
            r_blink <= ~r_blink;
         case (state)
            A_IN: if (w_pA_press && !mapA[w_idx]) begin
               mapA[w_idx] <= 1'b1;
               input_count <= input_count + 3'd1;
            end
            SHOW_A: if (w_tdone && input_count >= 3'd4) input_count <= '0;
            B_IN: if (w_pB_press && !mapB[w_idx]) begin
               mapB[w_idx] <= 1'b1;
               input_count <= input_count + 3'd1;
            end
            SHOW_B: if (w_tdone && input_count >= 3'd4) input_count <= '0;
            A_SHOOT: if (w_pA_press) begin
               r_hit <= mapB[w_idx];
               if (mapB[w_idx]) begin
                  mapB[w_idx] <= 1'b0;
                  if (score_A != 3'd4) score_A <= score_A + 3'd1;
               end
            end
            B_SHOOT: if (w_pB_press) begin
               r_hit <= mapA[w_idx];
               if (mapA[w_idx]) begin
                  mapA[w_idx] <= 1'b0;
                  if (score_B != 3'd4) score_B <= score_B + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      disp3 = 8'h00;
      disp2 = 8'h00;
      disp1 = 8'h00;
      disp0 = 8'h00;
      case (state)
         IDLE: begin
            disp3 = C_G_I;
            disp2 = C_G_D;
            disp1 = C_G_L;
            disp0 = C_G_E;
         end
         SHOW: disp3 = C_G_A;
         A_IN, B_IN: begin
            disp3 = f_digit({1'b0, X});
            disp2 = f_digit({1'b0, Y});
         end
         ERR_A, ERR_B: begin
            disp3 = C_G_E;
            disp2 = C_G_R;
            disp1 = C_G_R;
         end
         SHOW_A, SHOW_B: disp0 = f_digit(input_count);
         A_SHOOT, B_SHOOT: begin
            disp3 = f_digit({1'b0, X});
            disp2 = f_digit({1'b0, Y});
            disp1 = f_digit(score_A);
            disp0 = f_digit(score_B);
         end
         A_SINK, B_SINK: begin
            disp1 = f_digit(score_A);
            disp0 = f_digit(score_B);
            if (r_hit) begin
               disp3[7] = 1'b1;
               disp2[7] = 1'b1;
               disp1[7] = 1'b1;
               disp0[7] = 1'b1;
            end
         end
         A_WIN, B_WIN: begin
            disp3 = (state == A_WIN) ? C_G_A : C_G_B;
            disp2 = f_digit(score_A);
            disp1 = C_G_DASH;
            disp0 = f_digit(score_B);
         end
         default: ;
      endcase
   end

   always_comb begin
      led = 8'h00;
      case (state)
         IDLE:    led = 8'b1001_1001;
         A_IN: begin
            led[7]   = 1'b1;
            led[5:4] = input_count[1:0];
         end
         B_IN:    led[5:4] = input_count[1:0];
         A_SHOOT: led[7] = 1'b1;
         B_SHOOT: led[4] = 1'b1;
         A_WIN, B_WIN: led = r_blink ? 8'h00 : 8'hFF;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_battleship.sv
`default_nettype none
// tb_battleship : directed game vectors; expected state/display pairs are queued by
// the stimulus and checked by a monitor on every DUT state change.
module tb_battleship;
   localparam int TC = 8;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic       pAb   = 1'b0;
   logic       pBb   = 1'b0;
   logic [1:0] X     = 2'd0;
   logic [1:0] Y     = 2'd0;
   logic [7:0] disp3, disp2, disp1, disp0, led;

   battleship #(.TIMER_CYCLES(TC)) dut (
      .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .pAb(pAb), .pBb(pBb),
      .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0), .led(led)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  st;
      logic [31:0] disp;
   } exp_t;

   exp_t       scb[$];
   int         vectors     = 0;
   int         miscompares = 0;
   logic       mon_en      = 1'b0;
   logic [3:0] prev_st     = 4'd0;

   function automatic logic [7:0] dg(input int n);
      case (n)
         0:       dg = 8'h3F;
         1:       dg = 8'h06;
         2:       dg = 8'h5B;
         3:       dg = 8'h4F;
         4:       dg = 8'h66;
         default: dg = 8'h00;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && 4'(dut.state) != prev_st) begin
         prev_st = 4'(dut.state);
         vectors++;
         if (scb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_transition: state %0d, no transition expected", prev_st);
         end else begin
            e = scb.pop_front();
            if (prev_st != e.st || {disp3, disp2, disp1, disp0} != e.disp) begin
               miscompares++;
               $display("FAIL transition: got state %0d disp %h, expected state %0d disp %h",
                        prev_st, {disp3, disp2, disp1, disp0}, e.st, e.disp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int st, input logic [31:0] d);
      exp_t e;
      e.st   = st[3:0];
      e.disp = d;
      scb.push_back(e);
   endtask

   task automatic press(input bit is_b);
      if (is_b) pBb = 1'b1;
      else      pAb = 1'b1;
      step(10);
      pAb = 1'b0;
      pBb = 1'b0;
      step(10);
   endtask

   task automatic place(input bit is_b, input int x, input int y, input bit err,
                        input int cnt, input bit last);
      X = x[1:0];
      Y = y[1:0];
      step(1);
      if (err) begin
         push(is_b ? 6 : 3, 32'h7950_5000);
         push(is_b ? 5 : 2, {dg(x), dg(y), 16'h0});
      end else begin
         push(is_b ? 7 : 4, {24'h0, dg(cnt)});
         if (!last)      push(is_b ? 5 : 2, {dg(x), dg(y), 16'h0});
         else if (!is_b) push(5, {dg(x), dg(y), 16'h0});
         else            push(8, {dg(x), dg(y), dg(0), dg(0)});
      end
      press(is_b);
   endtask

   task automatic shoot(input bit is_b, input int x, input int y, input bit hit,
                        input int sa, input int sbv);
      X = x[1:0];
      Y = y[1:0];
      step(1);
      push(is_b ? 12 : 9, {16'h0, dg(sa), dg(sbv)} | (hit ? 32'h8080_8080 : 32'h0));
      if (!is_b) begin
         if (sa == 4) push(10, {8'h77, dg(sa), 8'h40, dg(sbv)});
         else         push(11, {dg(x), dg(y), dg(sa), dg(sbv)});
      end else begin
         if (sbv == 4) push(13, {8'h7C, dg(sa), 8'h40, dg(sbv)});
         else          push(8, {dg(x), dg(y), dg(sa), dg(sbv)});
      end
      press(is_b);
   endtask

   task automatic setup_game(input bit with_err);
      X = 2'd0;
      Y = 2'd0;
      push(1, 32'h7700_0000);
      push(2, {dg(0), dg(0), 16'h0});
      start = 1'b1;
      step(10);
      start = 1'b0;
      step(2);
      chk("state_a_in", 32'(dut.state), 32'd2);
      place(0, 0, 0, 0, 1, 0);
      if (with_err) begin
         place(0, 0, 0, 1, 1, 0);
         chk("count_after_err", 32'(dut.input_count), 32'd1);
      end
      place(0, 0, 1, 0, 2, 0);
      place(0, 1, 0, 0, 3, 0);
      place(0, 1, 1, 0, 4, 1);
      chk("mapA", 32'(dut.mapA), 32'h0033);
      chk("state_b_in", 32'(dut.state), 32'd5);
      place(1, 0, 0, 0, 1, 0);
      place(1, 0, 1, 0, 2, 0);
      place(1, 1, 0, 0, 3, 0);
      place(1, 1, 1, 0, 4, 1);
      chk("mapB", 32'(dut.mapB), 32'h0033);
      chk("state_a_shoot", 32'(dut.state), 32'd8);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_state"}, 32'(dut.state), 32'd0);
      chk({tag, "_disp"}, {disp3, disp2, disp1, disp0}, 32'h065E_3879);
      chk({tag, "_led"}, 32'(led), 32'h99);
      chk({tag, "_scores"}, {26'h0, dut.score_A, dut.score_B}, 32'h0);
      chk({tag, "_maps"}, {dut.mapA, dut.mapB}, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      step(10);
      check_reset("reset");
      rst = 1'b0;
      prev_st = 4'(dut.state);
      mon_en  = 1'b1;

      setup_game(1'b1);

      // Opponent's button during A's turn must not advance the game.
      pBb = 1'b1;
      step(10);
      pBb = 1'b0;
      step(5);
      chk("ignored_pBb", 32'(dut.state), 32'd8);

      shoot(0, 0, 0, 1, 1, 0);
      shoot(1, 0, 0, 1, 1, 1);
      shoot(0, 0, 1, 1, 2, 1);
      shoot(1, 1, 0, 1, 2, 2);
      shoot(0, 1, 1, 1, 3, 2);
      shoot(1, 1, 1, 1, 3, 3);
      shoot(0, 1, 1, 0, 3, 3);
      shoot(1, 0, 1, 1, 3, 4);
      chk("final_score_A", 32'(dut.score_A), 32'd3);
      chk("final_score_B", 32'(dut.score_B), 32'd4);
      chk("final_state", 32'(dut.state), 32'd13);
      step(3 * TC);
      chk("win_terminal", 32'(dut.state), 32'd13);
      chk("queue_drained_1", 32'(scb.size()), 32'd0);

      mon_en = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      scb.delete();
      prev_st = 4'(dut.state);
      mon_en  = 1'b1;
      setup_game(1'b0);
      shoot(0, 0, 0, 1, 1, 0);
      shoot(1, 2, 2, 0, 1, 0);
      chk("second_game_score_A", 32'(dut.score_A), 32'd1);
      chk("queue_drained_2", 32'(scb.size()), 32'd0);

      mon_en = 1'b0;
      rst = 1'b1;
      step(1);
      check_reset("midgame_reset");
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
